// File: rtl/div_pkg.sv
// Shared definitions for the phase-divider monitor family: FSM state type,
// default phase width and the modular phase-advance helper.
package div_pkg;

    localparam int unsigned CNT_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        ERR  = 2'd3
    } div_state_t;

    // Expected successor of a phase value of width w (wraps modulo 2**w).
    function automatic int unsigned next_phase(input int unsigned cnt, input int unsigned w);
        return (cnt + 32'd1) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/div_wrap_ctr.sv
// Free-running modulo-2**WRAP_W event counter; clear dominates increment.
module div_wrap_ctr #(
    parameter int unsigned WRAP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [WRAP_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/div_cnt_mon.sv
// Monitor for the divide-by-4 phase counter: checks +1 stepping, tracks lock,
// and derives the wrap tick, divided clock and locked-wrap count.
module div_cnt_mon
    import div_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned WRAP_W     = 16,
    parameter int unsigned ERR_STICKY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  pi_cnt,
    input  logic              pi_clr,
    output logic              po_tick,
    output logic              po_div,
    output logic              po_lock,
    output logic              po_err,
    output logic [WRAP_W-1:0] po_wrap_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       GOOD_LAST = 4'(LOCK_N - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       good;
    div_state_t       state;
    logic             step_ok;
    logic             wrap_det;
    logic             wrap_inc;

    assign cnt_nxt  = CNT_W'(next_phase(32'(cnt_q), CNT_W));
    assign step_ok  = (pi_cnt == cnt_nxt);
    assign wrap_det = (cnt_q == CNT_MAX) && (pi_cnt == '0);
    // Only wraps judged while already locked are counted.
    assign wrap_inc = wrap_det && (state == LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            po_tick <= 1'b0;
            po_div  <= 1'b0;
            good    <= '0;
            state   <= IDLE;
        end else begin
            cnt_q   <= pi_cnt;
            po_tick <= wrap_det;
            po_div  <= pi_cnt[CNT_W-1];
            unique case (state)
                IDLE: begin
                    state <= ACQ;
                    good  <= '0;
                end
                ACQ: begin
                    if (!step_ok) begin
                        good <= '0;
                    end else if (good == GOOD_LAST) begin
                        state <= LOCK;
                        good  <= '0;
                    end else begin
                        good <= good + 1'b1;
                    end
                end
                LOCK: begin
                    if (!step_ok) state <= ERR;
                end
                ERR: begin
                    if ((ERR_STICKY == 0) || pi_clr) begin
                        state <= ACQ;
                        good  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign po_lock = (state == LOCK);
    assign po_err  = (state == ERR);

    div_wrap_ctr #(
        .WRAP_W (WRAP_W)
    ) u_wrap_ctr (
        .clk (clk),
        .rst (rst),
        .clr (pi_clr),
        .inc (wrap_inc),
        .cnt (po_wrap_cnt)
    );

endmodule

// File: tb/tb_div_cnt_mon.sv
// Bench for div_cnt_mon: three parameter variants share one stimulus stream,
// each checked against its own behavioural model through a scoreboard queue.
module tb_div_cnt_mon;

    typedef struct packed {
        logic        tick;
        logic        div;
        logic        lock;
        logic        err;
        logic [15:0] wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pi_clr = 1'b0;
    logic [1:0] pi_cnt = 2'd0;

    logic        tick_a, div_a, lock_a, err_a;
    logic [15:0] wrap_a;
    logic        tick_b, div_b, lock_b, err_b;
    logic [15:0] wrap_b;
    logic        tick_c, div_c, lock_c, err_c;
    logic [2:0]  wrap_c;

    always #10 clk = ~clk;

    div_cnt_mon #(.CNT_W(2), .LOCK_N(4), .WRAP_W(16), .ERR_STICKY(1)) dut_a (
        .clk(clk), .rst(rst), .pi_cnt(pi_cnt), .pi_clr(pi_clr),
        .po_tick(tick_a), .po_div(div_a), .po_lock(lock_a), .po_err(err_a), .po_wrap_cnt(wrap_a));
    div_cnt_mon #(.CNT_W(2), .LOCK_N(4), .WRAP_W(16), .ERR_STICKY(0)) dut_b (
        .clk(clk), .rst(rst), .pi_cnt(pi_cnt), .pi_clr(pi_clr),
        .po_tick(tick_b), .po_div(div_b), .po_lock(lock_b), .po_err(err_b), .po_wrap_cnt(wrap_b));
    div_cnt_mon #(.CNT_W(2), .LOCK_N(4), .WRAP_W(3), .ERR_STICKY(1)) dut_c (
        .clk(clk), .rst(rst), .pi_cnt(pi_cnt), .pi_clr(pi_clr),
        .po_tick(tick_c), .po_div(div_c), .po_lock(lock_c), .po_err(err_c), .po_wrap_cnt(wrap_c));

    exp_t        sb[3][$];
    logic [1:0]  m_prev[3];
    int unsigned m_st[3];
    int unsigned m_good[3];
    int unsigned m_wrap[3];
    bit          sticky[3] = '{1'b1, 1'b0, 1'b1};
    int unsigned ww[3]     = '{16, 16, 3};
    string       nm[3]     = '{"a", "b", "c"};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [1:0]  ph = 2'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    // Model states: 0 idle, 1 acquiring, 2 locked, 3 error.
    task automatic model_step(input int i, input logic [1:0] c, input logic clr, input logic r);
        exp_t       e;
        logic [1:0] succ;
        bit         valid, wrapd;
        e = '0;
        if (r) begin
            m_prev[i] = 2'd0; m_st[i] = 0; m_good[i] = 0; m_wrap[i] = 0;
        end else begin
            succ  = m_prev[i] + 2'd1;
            valid = (c == succ);
            wrapd = (m_prev[i] == 2'd3) && (c == 2'd0);
            e.tick = wrapd;
            e.div  = c[1];
            if (clr) m_wrap[i] = 0;
            else if (wrapd && m_st[i] == 2) m_wrap[i] = (m_wrap[i] + 1) % (32'd1 << ww[i]);
            case (m_st[i])
                0: begin m_st[i] = 1; m_good[i] = 0; end
                1: begin
                    if (valid) begin
                        m_good[i]++;
                        if (m_good[i] == 4) begin m_st[i] = 2; m_good[i] = 0; end
                    end else m_good[i] = 0;
                end
                2: if (!valid) m_st[i] = 3;
                default: if (!sticky[i] || clr) begin m_st[i] = 1; m_good[i] = 0; end
            endcase
            m_prev[i] = c;
            e.lock = (m_st[i] == 2);
            e.err  = (m_st[i] == 3);
            e.wrap = 16'(m_wrap[i]);
        end
        sb[i].push_back(e);
    endtask

    function automatic exp_t observed(input int i);
        exp_t o;
        case (i)
            0:       o = '{tick_a, div_a, lock_a, err_a, wrap_a};
            1:       o = '{tick_b, div_b, lock_b, err_b, wrap_b};
            default: o = '{tick_c, div_c, lock_c, err_c, {13'd0, wrap_c}};
        endcase
        return o;
    endfunction

    task automatic step(input logic [1:0] c, input logic clr, input logic r);
        exp_t e, o;
        @(negedge clk);
        pi_cnt = c; pi_clr = clr; rst = r;
        for (int i = 0; i < 3; i++) model_step(i, c, clr, r);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = sb[i].pop_front();
            o = observed(i);
            check_val({nm[i], "_tick"}, 32'(o.tick), 32'(e.tick));
            check_val({nm[i], "_div"},  32'(o.div),  32'(e.div));
            check_val({nm[i], "_lock"}, 32'(o.lock), 32'(e.lock));
            check_val({nm[i], "_err"},  32'(o.err),  32'(e.err));
            check_val({nm[i], "_wrap"}, 32'(o.wrap), 32'(e.wrap));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            ph = ph + 2'd1;
            step(ph, 1'b0, 1'b0);
        end
    endtask

    task automatic lock_latency(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            ph = ph + 2'd1;
            step(ph, 1'b0, 1'b0);
            n++;
        end while (!lock_a && n < 20);
        check_val(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt, wk, errs;
        logic [15:0] wrap0;

        // Reset for 100 ns with the divider running.
        for (int k = 0; k < 5; k++) begin
            ph = ph + 2'd1;
            step(ph, 1'b0, 1'b1);
        end
        check_val("rst_lock", 32'(lock_a), 32'd0);
        check_val("rst_wrap", 32'(wrap_a), 32'd0);
        lock_latency("t1_lock_lat", 5);
        check_val("t1_err", 32'(err_a), 32'd0);

        // Eight full phase revolutions while locked.
        while (ph != 2'd3) run(1);
        wrap0 = wrap_a;
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            run(1);
            check_val("t2_tick_pos", 32'(tick_a), 32'(k % 4 == 0));
            cnt += int'(div_a);
        end
        check_val("t2_wrap_delta", 32'(16'(wrap_a - wrap0)), 32'd8);
        check_val("t2_div_duty", 32'(cnt), 32'd16);

        // Narrow counter rollover, then clear coincident with a tick.
        while (ph == 2'd3) run(1);
        ph = ph + 2'd1;
        step(ph, 1'b1, 1'b0);
        check_val("t5_clr", 32'(wrap_c), 32'd0);
        wk = 0;
        for (int k = 0; k < 60 && wk < 9; k++) begin
            run(1);
            if (tick_c) begin
                wk++;
                check_val("t5_wrap_seq", 32'(wrap_c), 32'(wk % 8));
            end
        end
        check_val("t5_wraps", 32'(wk), 32'd9);
        while (ph != 2'd3) run(1);
        ph = 2'd0;
        step(ph, 1'b1, 1'b0);
        check_val("t5_clr_tick", 32'(tick_c), 32'd1);
        check_val("t5_clr_wrap", 32'(wrap_c), 32'd0);

        // Reset pulse while locked with five counted wraps.
        run(20);
        check_val("t6_wrap5", 32'(wrap_a), 32'd5);
        ph = ph + 2'd1;
        step(ph, 1'b0, 1'b1);
        check_val("t6_rst_out", 32'({tick_a, div_a, lock_a, err_a, wrap_a}), 32'd0);
        lock_latency("t6_relock_lat", 5);

        // Skip 1 -> 3 while locked.
        while (ph != 2'd1) run(1);
        ph = 2'd3;
        step(ph, 1'b0, 1'b0);
        check_val("t3_err", 32'(err_a), 32'd1);
        check_val("t3_lock", 32'(lock_a), 32'd0);
        for (int k = 0; k < 3; k++) begin
            run(1);
            check_val("t3_err_hold", 32'(err_a), 32'd1);
        end
        ph = ph + 2'd1;
        step(ph, 1'b1, 1'b0);
        check_val("t3_clr_err", 32'(err_a), 32'd0);
        lock_latency("t3_relock_lat", 4);

        // Stall at 2 for two cycles.
        while (ph != 2'd2) run(1);
        check_val("t4_pre_lock", 32'(lock_b), 32'd1);
        errs = 0;
        for (int k = 0; k < 2; k++) begin
            step(ph, 1'b0, 1'b0);
            errs += int'(err_b);
        end
        for (int k = 0; k < 4; k++) begin
            run(1);
            errs += int'(err_b);
        end
        check_val("t4_err_cycles", 32'(errs), 32'd1);
        check_val("t4_sticky_err", 32'(err_a), 32'd1);

        // Mostly-valid random phase stream with occasional clears.
        ph = ph + 2'd1;
        step(ph, 1'b1, 1'b0);
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(9) == 0) ph = 2'($urandom_range(3));
            else ph = ph + 2'd1;
            step(ph, ($urandom_range(19) == 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
